blink_rtc: RTL and testbench
============================

// Module: blink_rtc
// PURPOSE
//  Parametrised real-time clock and timer-interrupt unit for the Blink gate array.
//  - Divides mck into 5 ms ticks and keeps a tick/second/minute count.
//  - Raises masked timer interrupts and serves the TIM0-4, TSTA, TACK and TMK I/O registers.
//  - Adds configurable tick rate, wrap limits and minute-counter width.
//  - Adds a coherent snapshot read of the multi-byte time.
//  - Sits beside the Blink I/O decoder; the tint output feeds the interrupt controller.
// PARAMETERS
//  TICK_DIV  49152  mck cycles per tick (9.8304 MHz * 5 ms)
//  TICK_MAX  200    ticks per second (TIM0 wraps at TICK_MAX-1)
//  SEC_MAX   60     seconds per minute (TIM1 wraps at SEC_MAX-1)
//  MIN_W     21     minute counter width, range 16..24 (spans TIM2, TIM3, TIM4)
// PORTS
//  mck        in   1  master clock; all state on rising edge
//  rin        in   1  reset, asynchronous, active-high
//  io_wr      in   1  one-cycle I/O write strobe
//  io_rd      in   1  one-cycle I/O read strobe
//  io_addr    in   8  I/O port address (Z80 ca[7:0])
//  io_wdata   in   8  write data
//  io_rdata   out  8  read data, registered
//  tim_clr    in   1  level input, COM bit 4 (RESTIM); holds the timers cleared
//  tsta       out  3  timer status: [0] tick, [1] second, [2] minute
//  tint       out  1  timer interrupt request, active-high
// BEHAVIOUR
//  - Reset (rin=1): prescaler, tim0..tim4, snapshot, tsta, tmk and io_rdata all go to 0; tint=0.
//  - Prescaler:
//    - Counts 0..TICK_DIV-1; a tick pulse occurs on the cycle it wraps to 0.
//    - tim0 increments on tick and wraps TICK_MAX-1 -> 0, producing a sec pulse.
//    - tim1 wraps SEC_MAX-1 -> 0, producing a min pulse.
//    - The minute counter (MIN_W bits) increments on min and wraps all-ones -> 0 silently.
//  - tim_clr=1: prescaler and all counters held at 0; no pulses are generated; tsta and tmk keep their values.
//    - Counting resumes from 0 on the first cycle after tim_clr falls.
//  - tsta[i] sets on its pulse (same edge the counter updates).
//    - A TACK write (io_wr, addr B4) clears each bit whose io_wdata bit is 1.
//    - Set and clear on the same cycle: the set wins.
//  - TMK write (io_wr, addr B5) loads tmk <= io_wdata[2:0].
//  - tint = |(tsta & tmk), combinational from registers; no glitch path from io_*.
//  - Reads: io_rd sampled at the edge; io_rdata updates on that edge and holds until the next io_rd. Decode:
//    - B5 -> {5'b0, tsta}
//    - D0 -> live tim0; the same edge latches the snapshot {tim1, min}
//    - D1 -> {2'b0, snap tim1}
//    - D2 -> snap min[7:0]
//    - D3 -> snap min[15:8]
//    - D4 -> snap min[MIN_W-1:16], zero-extended
//    - any other address -> 8'h00
//  - Reading D1..D4 without a prior D0 read returns the reset/last snapshot (coherent-read contract).
//  - io_wr and io_rd on the same cycle: both take effect; a read of B5 returns the pre-write tsta.
//  - Reset asserted mid-count: immediate clear; counting restarts from 0 after rin falls.
// STRUCTURE
//  - Shared package blink_pkg:
//    - I/O address constants IO_TACK=8'hB4, IO_TMK=8'hB5, IO_TSTA=8'hB5, IO_TIM0..IO_TIM4=8'hD0..8'hD4.
//    - tsta bit indices TS_TICK=0, TS_SEC=1, TS_MIN=2.
//  - One sub-module, blink_rtc_cnt:
//    - Modulo-N counter with parameters W and MAX; inputs en and clr; outputs q and carry.
//    - Instantiated for the prescaler, tim0 and tim1.
//  - The minute counter is a plain MIN_W-bit incrementer.
// TESTING (bench uses TICK_DIV=4, TICK_MAX=200, SEC_MAX=60, MIN_W=21)
//  1. Pulse rin mid-count -> tim0..tim4, tsta and io_rdata read 0; tint=0; tick again 4 cycles after rin falls.
//  2. Release tim_clr, run 4 cycles -> read D0 = 8'h01, B5 = 8'h01; tmk=0 so tint stays 0.
//  3. Write B5=8'h01, then write B4=8'h01 -> tint=1 before the TACK, 0 the cycle after.
//     - TACK coinciding with a tick -> tsta[0] stays 1.
//  4. Run 200 ticks -> D0=0, D1=1, tsta=3'b011.
//     - After 12000 ticks -> D2=1, tsta[2]=1.
//  5. Read D0 at tim1=59, tim0=199, one cycle before the minute rolls; read D1 and D2 after the rollover.
//     - D1 returns 59 and D2 returns 0 (snapshot), not the live 0/1.
//  6. Hold tim_clr=1 for 100 cycles with tsta=3'b111 -> counters stay 0, tsta stays 3'b111, no new pulses.

Source files
------------

// File: rtl/blink_pkg.sv
// Shared constants for the Blink RTC: I/O port addresses, tsta bit indices
// and a counter width helper.
package blink_pkg;

   localparam logic [7:0] IO_TACK = 8'hB4;
   localparam logic [7:0] IO_TMK  = 8'hB5;
   localparam logic [7:0] IO_TSTA = 8'hB5;
   localparam logic [7:0] IO_TIM0 = 8'hD0;
   localparam logic [7:0] IO_TIM1 = 8'hD1;
   localparam logic [7:0] IO_TIM2 = 8'hD2;
   localparam logic [7:0] IO_TIM3 = 8'hD3;
   localparam logic [7:0] IO_TIM4 = 8'hD4;

   localparam int unsigned TS_TICK = 0;
   localparam int unsigned TS_SEC  = 1;
   localparam int unsigned TS_MIN  = 2;

   // Bits needed to hold 0..max-1 (at least one bit).
   function automatic int unsigned cnt_width(input int unsigned max);
      return (max > 1) ? $clog2(max) : 1;
   endfunction

endpackage

// File: rtl/blink_rtc_cnt.sv
// Modulo-MAX counter with enable and synchronous clear.
// Ports: clk, rst (async, active-high), en (count), clr (hold at 0),
//        q (count value), carry (high on the cycle q wraps MAX-1 -> 0).
module blink_rtc_cnt #(
   parameter int unsigned W   = 8,
   parameter int unsigned MAX = 200
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] q,
   output logic         carry
);

   localparam logic [W-1:0] LAST = W'(MAX - 1);

   logic wrap;

   assign wrap  = (q == LAST);
   // carry is combinational so the next stage advances on the same edge.
   assign carry = en & ~clr & wrap;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en) begin
         q <= wrap ? '0 : q + W'(1);
      end
   end

endmodule

// File: rtl/blink_rtc.sv
// Blink real-time clock and timer-interrupt unit.
// Divides mck into ticks, counts ticks/seconds/minutes, raises masked
// timer interrupts and serves the TIM0-4, TSTA, TACK and TMK I/O ports.
// Ports: mck, rin (async active-high reset), io_wr/io_rd strobes, io_addr,
//        io_wdata, io_rdata (registered), tim_clr (hold timers cleared),
//        tsta (tick/sec/min status), tint (interrupt request).
module blink_rtc
   import blink_pkg::*;
#(
   parameter int unsigned TICK_DIV = 49152,
   parameter int unsigned TICK_MAX = 200,
   parameter int unsigned SEC_MAX  = 60,
   parameter int unsigned MIN_W    = 21
) (
   input  logic       mck,
   input  logic       rin,
   input  logic       io_wr,
   input  logic       io_rd,
   input  logic [7:0] io_addr,
   input  logic [7:0] io_wdata,
   output logic [7:0] io_rdata,
   input  logic       tim_clr,
   output logic [2:0] tsta,
   output logic       tint
);

   localparam int unsigned PW  = cnt_width(TICK_DIV);
   localparam int unsigned T0W = cnt_width(TICK_MAX);
   localparam int unsigned T1W = cnt_width(SEC_MAX);

   logic [PW-1:0]    pre;
   logic [T0W-1:0]   tim0;
   logic [T1W-1:0]   tim1;
   logic [MIN_W-1:0] minute;
   logic [T1W-1:0]   snap_sec;
   logic [MIN_W-1:0] snap_min;
   logic [2:0]       tmk;
   logic             tick;
   logic             sec;
   logic             min_p;
   logic [2:0]       pulse;
   logic [2:0]       ack;
   logic [7:0]       rd_mux;

   blink_rtc_cnt #(.W(PW), .MAX(TICK_DIV)) u_pre (
      .clk(mck), .rst(rin), .en(1'b1), .clr(tim_clr), .q(pre), .carry(tick)
   );

   blink_rtc_cnt #(.W(T0W), .MAX(TICK_MAX)) u_tim0 (
      .clk(mck), .rst(rin), .en(tick), .clr(tim_clr), .q(tim0), .carry(sec)
   );

   blink_rtc_cnt #(.W(T1W), .MAX(SEC_MAX)) u_tim1 (
      .clk(mck), .rst(rin), .en(sec), .clr(tim_clr), .q(tim1), .carry(min_p)
   );

   // Minute counter wraps silently at all-ones.
   always_ff @(posedge mck or posedge rin) begin
      if (rin) begin
         minute <= '0;
      end else if (tim_clr) begin
         minute <= '0;
      end else if (min_p) begin
         minute <= minute + MIN_W'(1);
      end
   end

   always_comb begin
      pulse          = 3'b000;
      pulse[TS_TICK] = tick;
      pulse[TS_SEC]  = sec;
      pulse[TS_MIN]  = min_p;
   end

   assign ack = (io_wr && (io_addr == IO_TACK)) ? io_wdata[2:0] : 3'b000;

   // Status: set wins over a simultaneous acknowledge.
   always_ff @(posedge mck or posedge rin) begin
      if (rin) begin
         tsta <= 3'b000;
         tmk  <= 3'b000;
      end else begin
         tsta <= (tsta & ~ack) | pulse;
         if (io_wr && (io_addr == IO_TMK)) begin
            tmk <= io_wdata[2:0];
         end
      end
   end

   assign tint = |(tsta & tmk);

   // Read decode; TIM1-4 come from the snapshot taken by the last TIM0 read.
   always_comb begin
      rd_mux = 8'h00;
      case (io_addr)
         IO_TSTA: rd_mux = {5'b0, tsta};
         IO_TIM0: rd_mux = 8'(tim0);
         IO_TIM1: rd_mux = 8'(snap_sec);
         IO_TIM2: rd_mux = 8'(snap_min);
         IO_TIM3: rd_mux = 8'(snap_min >> 8);
         IO_TIM4: rd_mux = 8'(snap_min >> 16);
         default: rd_mux = 8'h00;
      endcase
   end

   always_ff @(posedge mck or posedge rin) begin
      if (rin) begin
         io_rdata <= 8'h00;
         snap_sec <= '0;
         snap_min <= '0;
      end else if (io_rd) begin
         io_rdata <= rd_mux;
         if (io_addr == IO_TIM0) begin
            snap_sec <= tim1;
            snap_min <= minute;
         end
      end
   end

endmodule

// File: tb/tb_blink_rtc.sv
// Self-checking bench for blink_rtc with a fast prescaler (TICK_DIV=4).
// Reads push their expected byte into a scoreboard; a monitor compares
// io_rdata on the falling edge after each sampled read.
module tb_blink_rtc;

   logic       mck = 1'b0;
   logic       rin;
   logic       io_wr;
   logic       io_rd;
   logic [7:0] io_addr;
   logic [7:0] io_wdata;
   logic [7:0] io_rdata;
   logic       tim_clr;
   logic [2:0] tsta;
   logic       tint;

   int passed = 0;
   int total  = 0;

   logic [7:0] exp_q[$];
   logic [7:0] adr_q[$];
   logic       rd_seen = 1'b0;

   blink_rtc #(
      .TICK_DIV(4), .TICK_MAX(200), .SEC_MAX(60), .MIN_W(21)
   ) dut (
      .mck(mck), .rin(rin), .io_wr(io_wr), .io_rd(io_rd),
      .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata),
      .tim_clr(tim_clr), .tsta(tsta), .tint(tint)
   );

   always #5 mck = ~mck;

   // Scoreboard monitor.
   always @(posedge mck) rd_seen <= io_rd;

   always @(negedge mck) begin
      if (rd_seen) begin
         total++;
         if (exp_q.size() == 0) begin
            $display("FAIL rd_unexpected: io_rdata=%h with no expected value", io_rdata);
         end else begin
            logic [7:0] e;
            logic [7:0] a;
            e = exp_q.pop_front();
            a = adr_q.pop_front();
            if (io_rdata === e) passed++;
            else $display("FAIL rd_%h: got %h expected %h", a, io_rdata, e);
         end
      end
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge mck);
   endtask

   task automatic rd(input logic [7:0] a, input logic [7:0] e);
      io_rd = 1'b1; io_addr = a;
      exp_q.push_back(e); adr_q.push_back(a);
      @(negedge mck);
      io_rd = 1'b0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      io_wr = 1'b1; io_addr = a; io_wdata = d;
      @(negedge mck);
      io_wr = 1'b0;
   endtask

   task automatic rdwr(input logic [7:0] a, input logic [7:0] d, input logic [7:0] e);
      io_wr = 1'b1; io_rd = 1'b1; io_addr = a; io_wdata = d;
      exp_q.push_back(e); adr_q.push_back(a);
      @(negedge mck);
      io_wr = 1'b0; io_rd = 1'b0;
   endtask

   initial begin
      rin = 1'b1; tim_clr = 1'b0; io_wr = 1'b0; io_rd = 1'b0;
      io_addr = 8'h00; io_wdata = 8'h00;
      cyc(3);

      // 1: reset mid-count, then tick 4 cycles after release.
      rin = 1'b0;
      cyc(6);
      rd(8'hD0, 8'h01);
      rin = 1'b1;
      cyc(2);
      check("rst_rdata", io_rdata, 8'h00);
      check("rst_tsta", {5'b0, tsta}, 8'h00);
      check("rst_tint", {7'b0, tint}, 8'h00);
      rin = 1'b0;
      cyc(3);
      check("tick_early", {5'b0, tsta}, 8'h00);
      cyc(1);
      check("tick_at4", {5'b0, tsta}, 8'h01);

      tim_clr = 1'b1;
      cyc(1);
      rd(8'hD0, 8'h00);
      rd(8'hD1, 8'h00);
      rd(8'hD2, 8'h00);
      rd(8'hD3, 8'h00);
      rd(8'hD4, 8'h00);
      rd(8'hB5, 8'h01);
      rd(8'h55, 8'h00);
      wr(8'hB4, 8'h07);
      check("tack_all", {5'b0, tsta}, 8'h00);
      tim_clr = 1'b0;

      // 2: first tick after tim_clr release.
      cyc(4);
      rd(8'hD0, 8'h01);
      rd(8'hB5, 8'h01);
      check("tint_masked", {7'b0, tint}, 8'h00);

      // 3: mask enables tint; TACK on a tick keeps the bit; next TACK clears.
      wr(8'hB5, 8'h01);
      check("tint_on", {7'b0, tint}, 8'h01);
      wr(8'hB4, 8'h01);
      check("tack_vs_tick", {5'b0, tsta}, 8'h01);
      wr(8'hB4, 8'h01);
      check("tint_off", {7'b0, tint}, 8'h00);
      check("tsta_acked", {5'b0, tsta}, 8'h00);

      // 4: one second after 200 ticks.
      cyc(791);
      rd(8'hD0, 8'h00);
      rd(8'hD1, 8'h01);
      check("tsta_sec", {5'b0, tsta}, 8'h03);
      rd(8'hB5, 8'h03);

      // 5: snapshot one cycle before the minute rollover.
      cyc(47195);
      rd(8'hD0, 8'hC7);
      rd(8'hD1, 8'h3B);
      rd(8'hD2, 8'h00);
      check("tsta_min", {5'b0, tsta}, 8'h07);
      rd(8'hD0, 8'h00);
      rd(8'hD2, 8'h01);
      rd(8'hD1, 8'h00);
      rd(8'hD3, 8'h00);
      rd(8'hD4, 8'h00);

      // 6: tim_clr holds counters while status is retained.
      tim_clr = 1'b1;
      cyc(100);
      check("clr_tsta", {5'b0, tsta}, 8'h07);
      check("clr_tint", {7'b0, tint}, 8'h01);
      rd(8'hD0, 8'h00);
      rd(8'hD1, 8'h00);
      rd(8'hD2, 8'h00);
      rdwr(8'hB5, 8'h00, 8'h07);
      check("tmk_cleared", {7'b0, tint}, 8'h00);
      wr(8'hB4, 8'h07);
      cyc(20);
      check("clr_no_pulse", {5'b0, tsta}, 8'h00);
      tim_clr = 1'b0;
      cyc(4);
      check("resume_tick", {5'b0, tsta}, 8'h01);

      cyc(2);
      total++;
      if (exp_q.size() == 0) passed++;
      else $display("FAIL sb_drain: %0d reads left, expected 0", exp_q.size());

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
